// File: rtl/core_exec_pkg.sv
// Shared definitions for the multi-cycle execution core: opcodes, flag bit
// positions, FSM state encoding and a register-index width helper.
package core_exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADC  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_EOR  = 4'b0011;
    localparam logic [3:0] OP_SUBI = 4'b0101;
    localparam logic [3:0] OP_ORI  = 4'b0110;
    localparam logic [3:0] OP_ANDI = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_MOV  = 4'b1011;
    localparam logic [3:0] OP_LDI  = 4'b1110;

    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_exec_if.sv
// Instruction handshake between an instruction source and the execution core.
interface core_exec_if;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_ready;

    modport master (output inst_valid, inst, input inst_ready);
    modport slave  (input inst_valid, inst, output inst_ready);
endinterface

// File: rtl/core_exec_gpr.sv
// General-purpose register file: two operand read ports, a debug read port and
// one synchronous write port. Out-of-range indices read 0 and never write.
module gpr_file import core_exec_pkg::*; #(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    ra_sel,
    input  logic [3:0]    rb_sel,
    input  logic [3:0]    dbg_sel,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic [DW-1:0] dbg_data,
    input  logic          we,
    input  logic [3:0]    wsel,
    input  logic [DW-1:0] wdata
);
    localparam int         IW     = idx_w(NREG);
    localparam logic [4:0] NREG_L = 5'(NREG);

    logic [NREG-1:0][DW-1:0] regs;

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (we && ({1'b0, wsel} < NREG_L))
            regs[wsel[IW-1:0]] <= wdata;
    end

    assign ra_data  = ({1'b0, ra_sel}  < NREG_L) ? regs[ra_sel[IW-1:0]]  : '0;
    assign rb_data  = ({1'b0, rb_sel}  < NREG_L) ? regs[rb_sel[IW-1:0]]  : '0;
    assign dbg_data = ({1'b0, dbg_sel} < NREG_L) ? regs[dbg_sel[IW-1:0]] : '0;

endmodule

// File: rtl/core_exec.sv
// Multi-cycle execution core: FETCH latches an instruction, EXEC computes the
// result and flags into holding registers, WB commits them and pulses retire.
module core_exec import core_exec_pkg::*; #(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  logic          clk,
    input  logic          rst,
    core_exec_if.slave    inst_if,
    output logic          retire,
    output logic          busy,
    output logic [3:0]    flags,
    input  logic [3:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);
    state_t        state, state_nxt;
    logic [15:0]   ir;
    logic [3:0]    op, rd, rr;
    logic [7:0]    k;
    logic [DW-1:0] a, b_reg, b, res, res_q;
    logic [DW:0]   sum;
    logic [3:0]    flg, flg_q;
    logic          wr, wr_q, upd_nz, cin;

    assign op = ir[15:12];
    assign rd = ir[7:4];
    assign rr = ir[3:0];
    assign k  = {ir[11:8], ir[3:0]};

    gpr_file #(.DW(DW), .NREG(NREG)) u_gpr (
        .clk      (clk),
        .rst      (rst),
        .ra_sel   (rd),
        .rb_sel   (rr),
        .dbg_sel  (dbg_sel),
        .ra_data  (a),
        .rb_data  (b_reg),
        .dbg_data (dbg_data),
        .we       ((state == ST_WB) && wr_q),
        .wsel     (rd),
        .wdata    (res_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nxt;
    end

    // Reset abandons an in-flight instruction, so retire is masked by rst.
    always_comb begin
        state_nxt          = state;
        inst_if.inst_ready = 1'b0;
        retire             = 1'b0;
        busy               = 1'b0;
        unique case (state)
            ST_FETCH: begin
                inst_if.inst_ready = !rst;
                if (inst_if.inst_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                busy      = 1'b1;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                busy      = 1'b1;
                retire    = !rst;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // ALU; immediates use zero-extended K in place of the rr operand.
    always_comb begin
        b      = (op inside {OP_SUBI, OP_ORI, OP_ANDI, OP_LDI}) ? DW'(k) : b_reg;
        cin    = (op == OP_ADC) && flags[FLG_C];
        res    = a;
        flg    = flags;
        wr     = 1'b1;
        upd_nz = 1'b1;
        sum    = '0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                sum        = {1'b0, a} + {1'b0, b} + (DW+1)'(cin);
                res        = sum[DW-1:0];
                flg[FLG_C] = sum[DW];
                flg[FLG_V] = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
            end
            OP_SUB, OP_SUBI: begin
                sum        = {1'b0, a} - {1'b0, b};
                res        = sum[DW-1:0];
                flg[FLG_C] = sum[DW];
                flg[FLG_V] = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
            end
            OP_AND, OP_ANDI: begin
                res        = a & b;
                flg[FLG_V] = 1'b0;
            end
            OP_EOR: begin
                res        = a ^ b;
                flg[FLG_V] = 1'b0;
            end
            OP_OR, OP_ORI: begin
                res        = a | b;
                flg[FLG_V] = 1'b0;
            end
            OP_MOV, OP_LDI: begin
                res    = b;
                upd_nz = 1'b0;
            end
            default: begin
                wr     = 1'b0;
                upd_nz = 1'b0;
            end
        endcase
        if (upd_nz) begin
            flg[FLG_Z] = (res == '0);
            flg[FLG_N] = res[DW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir    <= '0;
            res_q <= '0;
            flg_q <= '0;
            wr_q  <= 1'b0;
            flags <= '0;
        end else begin
            if (state == ST_FETCH && inst_if.inst_valid) ir <= inst_if.inst;
            if (state == ST_EXEC) begin
                res_q <= res;
                flg_q <= flg;
                wr_q  <= wr;
            end
            if (state == ST_WB) flags <= flg_q;
        end
    end

endmodule

// File: tb/tb_core_exec.sv
// Bench for core_exec: directed scenarios plus random instruction streams
// compared against an integer-arithmetic model of the instruction set.
module tb_core_exec;
    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int MOD  = 1 << DW;
    localparam int HALF = MOD / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          retire, busy;
    logic [3:0]    flags;
    logic [3:0]    dbg_sel;
    logic [DW-1:0] dbg_data;

    core_exec_if bus ();

    core_exec #(.DW(DW), .NREG(NREG)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst_if  (bus),
        .retire   (retire),
        .busy     (busy),
        .flags    (flags),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #10 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         mreg[NREG];
    logic [3:0] mflg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) mreg[r] = 0;
        mflg = 4'b0000;
    endtask

    // Flags are {C,Z,V,N}; arithmetic is done on plain integers.
    task automatic model_exec(input logic [15:0] i);
        int op, rd, rr, k, a, b, res, full, s, ci;
        bit wr, upd, c, v;
        op  = i[15:12];
        rd  = i[7:4];
        rr  = i[3:0];
        k   = {i[11:8], i[3:0]};
        a   = (rd < NREG) ? mreg[rd] : 0;
        b   = (op inside {5, 6, 7, 14}) ? k : ((rr < NREG) ? mreg[rr] : 0);
        ci  = (op == 1 && mflg[3]) ? 1 : 0;
        c   = mflg[3];
        v   = mflg[1];
        wr  = 1'b1;
        upd = 1'b1;
        res = 0;
        case (op)
            0, 1: begin
                full = a + b + ci;
                res  = full % MOD;
                c    = (full >= MOD);
                s    = sx(a) + sx(b) + ci;
                v    = (s >= HALF) || (s < -HALF);
            end
            5, 9: begin
                res = (a - b + MOD) % MOD;
                c   = (a < b);
                s   = sx(a) - sx(b);
                v   = (s >= HALF) || (s < -HALF);
            end
            2, 7:  begin res = a & b; v = 1'b0; end
            3:     begin res = a ^ b; v = 1'b0; end
            6, 8:  begin res = a | b; v = 1'b0; end
            11:    begin res = b; upd = 1'b0; end
            14:    begin res = k; upd = 1'b0; end
            default: begin wr = 1'b0; upd = 1'b0; end
        endcase
        if (wr && rd < NREG) mreg[rd] = res;
        if (upd) mflg = {c, (res == 0), v, (res >= HALF)};
    endtask

    task automatic chk_state(input string tag);
        for (int r = 0; r < NREG; r++) begin
            dbg_sel = 4'(r);
            #1 chk({tag, "_reg"}, dbg_data, mreg[r]);
        end
        dbg_sel = 4'($urandom_range(NREG, 15));
        #1 chk({tag, "_oob"}, dbg_data, 0);
        chk({tag, "_flags"}, flags, mflg);
    endtask

    task automatic rd_dbg(input int idx, output logic [DW-1:0] v);
        dbg_sel = 4'(idx);
        #1 v = dbg_data;
    endtask

    // Fixed-latency issue: accept, EXEC, WB (retire), then FETCH again.
    task automatic run_inst(input logic [15:0] i);
        bus.inst       = i;
        bus.inst_valid = 1'b1;
        #1 chk("acc_ready", bus.inst_ready, 1);
        @(posedge clk);
        model_exec(i);
        @(negedge clk);
        bus.inst = 16'($urandom);
        #1 chk("exec_busy", busy, 1);
        chk("exec_retire", retire, 0);
        chk("exec_ready", bus.inst_ready, 0);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        #1 chk("wb_retire", retire, 1);
        chk("wb_busy", busy, 1);
        @(negedge clk);
        #1 chk("fetch_retire", retire, 0);
        chk("fetch_ready", bus.inst_ready, 1);
        chk_state("post");
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.inst_valid = 1'b0;
            #1 chk("idle_ready", bus.inst_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_retire", retire, 0);
        end
    endtask

    function automatic logic [15:0] rand_inst();
        logic [3:0] op, mid, rd, rr;
        op  = 4'($urandom_range(0, 15));
        mid = 4'($urandom);
        rd  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        rr  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        return {op, mid, rd, rr};
    endfunction

    task automatic rst_mid(input logic [15:0] i, input bit at_wb);
        bus.inst       = i;
        bus.inst_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        if (at_wb) begin
            #1 chk("rmid_exec_retire", retire, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1 chk("rmid_retire", retire, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1 chk("rmid_ready", bus.inst_ready, 1);
        chk("rmid_busy", busy, 0);
        chk("rmid_ret_after", retire, 0);
        chk_state("rmid");
        idle(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        logic [15:0]   prog[3];
        int            idx, rc;
        bit            acc;

        rst            = 1'b1;
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        dbg_sel        = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_ready", bus.inst_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_retire", retire, 0);
        chk_state("rst");

        run_inst(16'hE71F);
        rd_dbg(1, v); chk("t1_r1", v, 8'h7F); chk("t1_flags", flags, 4'b0000);
        run_inst(16'hE021);
        run_inst(16'h0012);
        rd_dbg(1, v); chk("t2_r1", v, 8'h80); chk("t2_flags", flags, 4'b0011);
        run_inst(16'hEF0F);
        run_inst(16'hE031);
        run_inst(16'h0003);
        rd_dbg(0, v); chk("t3_r0", v, 8'h00); chk("t3_flags", flags, 4'b1100);
        run_inst(16'h1033);
        rd_dbg(3, v); chk("t3_r3", v, 8'h03); chk("t3_adc_flags", flags, 4'b0000);
        run_inst(16'h5035);
        rd_dbg(3, v); chk("t4_r3", v, 8'hFE); chk("t4_flags", flags, 4'b1001);
        run_inst(16'h703F);
        rd_dbg(3, v); chk("t4_andi_r3", v, 8'h0E); chk("t4_andi_flags", flags, 4'b1000);
        run_inst(16'hE353);
        rd_dbg(3, v); chk("t4_ldi_r3", v, 8'h0E);

        // Back-to-back with inst_valid held high for three instructions.
        idle(1);
        for (int j = 0; j < 3; j++) prog[j] = rand_inst();
        idx = 0;
        rc  = 0;
        for (int c = 0; c < 12; c++) begin
            bus.inst_valid = (idx < 3);
            bus.inst       = prog[(idx < 3) ? idx : 0];
            #1 chk("b2b_ready", bus.inst_ready, (c < 9) ? ((c % 3) == 0) : 1);
            if (retire) rc++;
            acc = bus.inst_valid && bus.inst_ready;
            @(posedge clk);
            if (acc) begin
                model_exec(prog[idx]);
                idx++;
            end
            @(negedge clk);
        end
        chk("b2b_retires", rc, 3);
        chk_state("b2b");

        for (int n = 0; n < 150; n++) begin
            idle($urandom_range(0, 2));
            run_inst(rand_inst());
        end

        // Reset during EXEC and during WB of an ADD that would change state.
        run_inst(16'hE813);
        run_inst(16'hE024);
        rst_mid(16'h0012, 1'b0);
        run_inst(16'hE810);
        run_inst(16'hE820);
        run_inst(16'h0012);
        rst_mid(16'h0012, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/core_exec.md
Name: core_exec

Overview:
Parametrised multi-cycle execution core: the next generation of the 8-bit core. It takes instructions over a valid/ready handshake, decodes them, executes them in a DW-bit ALU, then writes back to a register file and status register. Run order per instruction is FETCH -> EXEC -> WB. It sits between an instruction source (bench or fetch unit) and the register/flag state, and exposes a debug read port.

Parameters:
DW, 8, datapath width in bits (8..32)
NREG, 4, number of general-purpose registers (power of 2, 2..16)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
inst_valid  in  1  instruction offered
inst  in  16  instruction word
inst_ready  out  1  core accepts inst this cycle
retire  out  1  one-cycle pulse: instruction committed at end of this cycle
busy  out  1  high in EXEC or WB
flags  out  4  status {C,Z,V,N} = bits 3..0
dbg_sel  in  4  debug register index
dbg_data  out  DW  combinational read of register dbg_sel (0 if index >= NREG)

Behaviour:
- Reset: synchronous, active-high; clock clk.
  - On a rst edge: state=FETCH, IR=0, all registers=0, flags=0.
  - After that edge: inst_ready=1, retire=0, busy=0.
  - rst has priority over every other event, including a handshake in the same cycle.
- Encoding:
  - op=inst[15:12], rd=inst[7:4], rr=inst[3:0].
  - K={inst[11:8],inst[3:0]}, zero-extended to DW.
- Register ops:
  - ADD 0000: rd=rd+rr.
  - ADC 0001: rd=rd+rr+C.
  - AND 0010.
  - EOR 0011.
  - OR 1000.
  - SUB 1001: rd=rd-rr.
  - MOV 1011: rd=rr.
- Immediate ops:
  - SUBI 0101.
  - ORI 0110.
  - ANDI 0111.
  - LDI 1110: rd=K.
- Any other opcode is a NOP: it retires, with no register write and no flag change.
- FSM:
  - FETCH: inst_ready=1. On inst_valid at the edge, latch inst into IR and go to EXEC; otherwise stay in FETCH.
  - EXEC: read operands, compute result, register result and new flags; go to WB.
  - WB: retire=1. At the end of WB, write rd and flags; go to FETCH.
- Timing:
  - Accept edge E0. rd is visible on dbg_data after edge E2.
  - Minimum 3 cycles per instruction. inst_ready pattern under continuous valid is 1,0,0.
  - inst/inst_valid are ignored outside FETCH.
- Flags:
  - ADD/ADC: C=carry out of bit DW-1; V=signed overflow; N=msb; Z=(res==0).
  - SUB/SUBI: C=borrow (a<b unsigned, including carry-in for none); V=signed overflow; N, Z as above.
  - AND/EOR/OR/ANDI/ORI: C unchanged, V=0, N and Z updated.
  - LDI/MOV/NOP: flags unchanged.
  - ADC reads C as committed by the previous instruction.
- Range handling:
  - rd >= NREG: the write is discarded, the instruction still retires, and flags update normally.
  - Reads with index >= NREG return 0.
- Results wrap modulo 2^DW.
- Reset mid-EXEC or mid-WB: the instruction is abandoned with no retire and no write; next cycle is FETCH.

Decomposition:
- Package core_exec_pkg:
  - opcode constants
  - flag indices C=3, Z=2, V=1, N=0
  - state encoding FETCH/EXEC/WB
  - width helper for the register index
- Sub-module gpr_file #(DW,NREG):
  - two combinational read ports plus a debug read port
  - one synchronous write port with enable
  - synchronous reset to 0
- The ALU and FSM stay in core_exec.

Test Plan (all with DW=8, NREG=4):
1. Reset, then LDI R1,0x7F (16'hE71F) -> retire 2 cycles after accept; dbg R1=0x7F; flags=4'b0000.
2. LDI R2,0x01 (16'hE021), then ADD R1,R2 (16'h0012) -> R1=0x80; flags=4'b0011 (V,N).
3. LDI R0,0xFF (16'hEF0F), LDI R3,0x01 (16'hE031), ADD R0,R3 (16'h0003) -> R0=0x00, flags=4'b1100. Then ADC R3,R3 (16'h1033) -> R3=0x03, flags=4'b0000.
4. With R3=0x03: SUBI R3,0x05 (16'h5035) -> R3=0xFE, flags=4'b1001. Then ANDI R3,0x0F (16'h703F) -> R3=0x0E, flags=4'b1000 (C kept). Then LDI R5,0x33 (16'hE353) -> retire=1, R0..R3 unchanged.
5. inst_valid held high with 3 instructions back-to-back -> inst_ready sequence 1,0,0 repeating; exactly 3 retire pulses. Then inst_valid=0 -> core stays in FETCH, no further retire.
6. rst asserted in the EXEC cycle of ADD R1,R2 -> no retire; all registers 0, flags 0; inst_ready=1 the cycle after the reset edge.
